regfile_wb_arbiter: RTL and testbench

//  Shares the single register-file write port between NUM_REQ writeback sources (ALU, load unit, link/mul-div).

---
 rtl/regfile_arb_pkg.sv | 10 +
 rtl/regfile_wb_arbiter_if.sv | 17 +
 rtl/rr_arbiter.sv | 33 +++
 rtl/regfile_wb_arbiter.sv | 142 ++++++++++++++
 tb/tb_regfile_wb_arbiter.sv | 286 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/regfile_arb_pkg.sv
// rtl/regfile_arb_pkg.sv - shared widths and types for the writeback arbiter
// Contents: REG_IDX_W, DATA_W, NUM_REGS, reg_idx_t, reg_data_t.
package regfile_arb_pkg;
  localparam int REG_IDX_W = 5;
  localparam int DATA_W    = 32;
  localparam int NUM_REGS  = 32;

  typedef logic [REG_IDX_W-1:0] reg_idx_t;
  typedef logic [DATA_W-1:0]    reg_data_t;
endpackage

// File: rtl/regfile_wb_arbiter_if.sv
// rtl/regfile_wb_arbiter_if.sv - writeback requester bus (NUM_REQ sources)
// Signals: req_valid[NUM_REQ], req_ready[NUM_REQ] (one-hot grant),
//          req_index[NUM_REQ*5] (slice i = [5i+4:5i]), req_data[NUM_REQ*32].
// Modports: master (writeback sources), slave (arbiter).
interface regfile_wb_arbiter_if #(
  parameter int NUM_REQ = 3
) ();
  import regfile_arb_pkg::*;

  logic [NUM_REQ-1:0]           req_valid;
  logic [NUM_REQ-1:0]           req_ready;
  logic [NUM_REQ*REG_IDX_W-1:0] req_index;
  logic [NUM_REQ*DATA_W-1:0]    req_data;

  modport master (output req_valid, output req_index, output req_data, input req_ready);
  modport slave  (input req_valid, input req_index, input req_data, output req_ready);
endinterface

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin grant from a request vector and pointer
// Ports: req (in, NUM_REQ), ptr (in, last granted index),
//        grant (out, one-hot or zero), grant_idx (out), grant_any (out).
module rr_arbiter #(
  parameter int NUM_REQ = 3,
  parameter int PTR_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [PTR_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [PTR_W-1:0]   grant_idx,
  output logic               grant_any
);

  // Scan starts one past the last winner and wraps, so the last winner
  // is considered last.
  always_comb begin
    int j;
    j         = 0;
    grant     = '0;
    grant_idx = '0;
    grant_any = 1'b0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      j = (int'(ptr) + k) % NUM_REQ;
      if (!grant_any && req[j]) begin
        grant[j]  = 1'b1;
        grant_idx = PTR_W'(j);
        grant_any = 1'b1;
      end
    end
  end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// rtl/regfile_wb_arbiter.sv - round-robin register-file write port arbiter with RAW scoreboard
// Ports: clk, reset (sync, active-high); wb (requester bus, slave modport);
//        rf_write_en/index/data (registered write port); rsv_valid/rsv_index/rsv_ready
//        (dest reservation); q_index1/2 -> q_busy1/2 (pending-write queries).
// Option REGFILE_ARB_BYPASS_EN adds q_byp_valid1/2 and q_byp_data1/2 so a query
// that hits the final committing write sees the data instead of busy.
module regfile_wb_arbiter
  import regfile_arb_pkg::*;
#(
  parameter int NUM_REQ = 3,
  parameter int CNT_W   = 2
) (
  input  logic      clk,
  input  logic      reset,
  regfile_wb_arbiter_if.slave wb,
  output logic      rf_write_en,
  output reg_idx_t  rf_write_index,
  output reg_data_t rf_write_data,
  input  logic      rsv_valid,
  input  reg_idx_t  rsv_index,
  output logic      rsv_ready,
  input  reg_idx_t  q_index1,
  input  reg_idx_t  q_index2,
  output logic      q_busy1,
  output logic      q_busy2
`ifdef REGFILE_ARB_BYPASS_EN
  ,
  output logic      q_byp_valid1,
  output logic      q_byp_valid2,
  output reg_data_t q_byp_data1,
  output reg_data_t q_byp_data2
`endif
);

  localparam int PTR_W = $clog2(NUM_REQ);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [PTR_W-1:0]   rr_ptr;
  logic [PTR_W-1:0]   grant_idx;
  logic [NUM_REQ-1:0] grant;
  logic               grant_any;
  reg_idx_t           sel_index;
  reg_data_t          sel_data;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .PTR_W   (PTR_W)
  ) u_rr (
    .req       (wb.req_valid),
    .ptr       (rr_ptr),
    .grant     (grant),
    .grant_idx (grant_idx),
    .grant_any (grant_any)
  );

  // No transfer is accepted while reset is held.
  assign wb.req_ready = reset ? '0 : grant;

  assign sel_index = wb.req_index[grant_idx*REG_IDX_W +: REG_IDX_W];
  assign sel_data  = wb.req_data[grant_idx*DATA_W +: DATA_W];

  // Writes to x0 are accepted but never reach the register file.
  always_ff @(posedge clk) begin
    if (reset) begin
      rr_ptr         <= PTR_W'(NUM_REQ - 1);
      rf_write_en    <= 1'b0;
      rf_write_index <= '0;
      rf_write_data  <= '0;
    end else begin
      rf_write_en <= grant_any && (sel_index != '0);
      if (grant_any) begin
        rr_ptr         <= grant_idx;
        rf_write_index <= sel_index;
        rf_write_data  <= sel_data;
      end
    end
  end

  logic [CNT_W-1:0] cnt      [NUM_REGS];
  logic [CNT_W-1:0] cnt_next [NUM_REGS];
  logic             commit_to_rsv;

  // A commit in the same cycle frees a slot, so a saturated register can
  // still take a reservation then.
  assign commit_to_rsv = rf_write_en && (rf_write_index == rsv_index);
  assign rsv_ready     = (rsv_index == '0) || (cnt[rsv_index] != CNT_MAX) || commit_to_rsv;

  always_comb begin
    logic inc;
    logic dec;
    inc = 1'b0;
    dec = 1'b0;
    for (int r = 0; r < NUM_REGS; r++) begin
      inc = rsv_valid && rsv_ready && (rsv_index == reg_idx_t'(r)) && (r != 0);
      dec = rf_write_en && (rf_write_index == reg_idx_t'(r));
      cnt_next[r] = cnt[r];
      if (inc && !dec) begin
        cnt_next[r] = cnt[r] + CNT_ONE;
      end else if (dec && !inc && (cnt[r] != '0)) begin
        // Unreserved commits leave the counter at zero.
        cnt_next[r] = cnt[r] - CNT_ONE;
      end
    end
    cnt_next[0] = '0;
  end

  always_ff @(posedge clk) begin
    for (int r = 0; r < NUM_REGS; r++) begin
      if (reset) begin
        cnt[r] <= '0;
      end else begin
        cnt[r] <= cnt_next[r];
      end
    end
  end

  logic busy_raw1;
  logic busy_raw2;
  assign busy_raw1 = (q_index1 != '0) && (cnt[q_index1] != '0);
  assign busy_raw2 = (q_index2 != '0) && (cnt[q_index2] != '0);

`ifdef REGFILE_ARB_BYPASS_EN
  // The last outstanding write is on the write port now: forward it.
  logic byp_hit1;
  logic byp_hit2;
  assign byp_hit1 = rf_write_en && (rf_write_index == q_index1) && (q_index1 != '0) &&
                    (cnt[q_index1] == CNT_ONE);
  assign byp_hit2 = rf_write_en && (rf_write_index == q_index2) && (q_index2 != '0) &&
                    (cnt[q_index2] == CNT_ONE);
  assign q_busy1      = busy_raw1 && !byp_hit1;
  assign q_busy2      = busy_raw2 && !byp_hit2;
  assign q_byp_valid1 = byp_hit1;
  assign q_byp_valid2 = byp_hit2;
  assign q_byp_data1  = rf_write_data;
  assign q_byp_data2  = rf_write_data;
`else
  assign q_busy1 = busy_raw1;
  assign q_busy2 = busy_raw2;
`endif

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// tb/tb_regfile_wb_arbiter.sv - scoreboard bench for regfile_wb_arbiter
module tb_regfile_wb_arbiter;
  localparam int NR   = 3;
  localparam int CMAX = 3;

  logic        clk = 1'b0;
  logic        reset;
  logic        rf_write_en;
  logic [4:0]  rf_write_index;
  logic [31:0] rf_write_data;
  logic        rsv_valid;
  logic [4:0]  rsv_index;
  logic        rsv_ready;
  logic [4:0]  q_index1, q_index2;
  logic        q_busy1, q_busy2;
`ifdef REGFILE_ARB_BYPASS_EN
  logic        q_byp_valid1, q_byp_valid2;
  logic [31:0] q_byp_data1, q_byp_data2;
`endif

  regfile_wb_arbiter_if #(.NUM_REQ(NR)) bus ();

  regfile_wb_arbiter #(.NUM_REQ(NR), .CNT_W(2)) dut (
    .clk            (clk),
    .reset          (reset),
    .wb             (bus),
    .rf_write_en    (rf_write_en),
    .rf_write_index (rf_write_index),
    .rf_write_data  (rf_write_data),
    .rsv_valid      (rsv_valid),
    .rsv_index      (rsv_index),
    .rsv_ready      (rsv_ready),
    .q_index1       (q_index1),
    .q_index2       (q_index2),
    .q_busy1        (q_busy1),
    .q_busy2        (q_busy2)
`ifdef REGFILE_ARB_BYPASS_EN
    ,
    .q_byp_valid1   (q_byp_valid1),
    .q_byp_valid2   (q_byp_valid2),
    .q_byp_data1    (q_byp_data1),
    .q_byp_data2    (q_byp_data2)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [NR-1:0] ready;
    logic          en;
    logic [4:0]    idx;
    logic [31:0]   data;
    logic          rsv_rdy;
    logic          b1, b2;
    logic          bv1, bv2;
    logic [31:0]   bd;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  // Reference model: pending-write counts, last winner, and the write the
  // port is presenting this cycle.
  int          m_cnt[32];
  int          m_last;
  logic        m_en;
  int          m_idx;
  logic [31:0] m_data;

  task automatic model_reset();
    for (int r = 0; r < 32; r++) m_cnt[r] = 0;
    m_last = NR - 1;
    m_en   = 1'b0;
    m_idx  = 0;
    m_data = 32'h0;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h @%0t", name, act, req, $time);
    end
  endtask

  task automatic set_req(input int i, input logic v, input int idx, input logic [31:0] d);
    bus.req_valid[i]        = v;
    bus.req_index[i*5 +: 5] = 5'(idx);
    bus.req_data[i*32 +: 32] = d;
  endtask

  task automatic clear_inputs();
    bus.req_valid = '0;
    bus.req_index = '0;
    bus.req_data  = '0;
    rsv_valid     = 1'b0;
    rsv_index     = '0;
    q_index1      = '0;
    q_index2      = '0;
  endtask

  function automatic logic busy_of(input int q);
    return (q != 0) && (m_cnt[q] != 0);
  endfunction

  function automatic logic byp_of(input int q);
`ifdef REGFILE_ARB_BYPASS_EN
    return m_en && (m_idx == q) && (q != 0) && (m_cnt[q] == 1);
`else
    return 1'b0;
`endif
  endfunction

  // Predict this cycle's outputs, queue them, advance the model, advance time.
  task automatic step();
    exp_t e;
    int   g;
    int   ri;
    logic rr;
    g = -1;
    if (!reset) begin
      for (int k = 1; k <= NR; k++) begin
        int j;
        j = (m_last + k) % NR;
        if (g < 0 && bus.req_valid[j]) g = j;
      end
    end
    e.ready = '0;
    if (g >= 0) e.ready[g] = 1'b1;
    e.en   = m_en;
    e.idx  = 5'(m_idx);
    e.data = m_data;
    ri = int'(rsv_index);
    rr = (ri == 0) || (m_cnt[ri] < CMAX) || (m_en && m_idx == ri);
    e.rsv_rdy = rr;
    e.bv1 = byp_of(int'(q_index1));
    e.bv2 = byp_of(int'(q_index2));
    e.b1  = busy_of(int'(q_index1)) && !e.bv1;
    e.b2  = busy_of(int'(q_index2)) && !e.bv2;
    e.bd  = m_data;
    exp_q.push_back(e);

    if (reset) begin
      model_reset();
    end else begin
      for (int r = 1; r < 32; r++) begin
        bit inc, dec;
        inc = rsv_valid && rr && (ri == r);
        dec = m_en && (m_idx == r);
        if (inc && !dec) m_cnt[r]++;
        else if (dec && !inc && m_cnt[r] > 0) m_cnt[r]--;
      end
      if (g >= 0) begin
        m_last = g;
        m_idx  = int'(bus.req_index[g*5 +: 5]);
        m_data = bus.req_data[g*32 +: 32];
        m_en   = (m_idx != 0);
      end else begin
        m_en = 1'b0;
      end
    end
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      chk("req_ready", 32'(bus.req_ready), 32'(e.ready));
      chk("rf_write_en", 32'(rf_write_en), 32'(e.en));
      chk("rf_write_index", 32'(rf_write_index), 32'(e.idx));
      chk("rf_write_data", rf_write_data, e.data);
      chk("rsv_ready", 32'(rsv_ready), 32'(e.rsv_rdy));
      chk("q_busy1", 32'(q_busy1), 32'(e.b1));
      chk("q_busy2", 32'(q_busy2), 32'(e.b2));
`ifdef REGFILE_ARB_BYPASS_EN
      chk("q_byp_valid1", 32'(q_byp_valid1), 32'(e.bv1));
      chk("q_byp_valid2", 32'(q_byp_valid2), 32'(e.bv2));
      if (e.bv1) chk("q_byp_data1", q_byp_data1, e.bd);
      if (e.bv2) chk("q_byp_data2", q_byp_data2, e.bd);
`endif
    end
  end

  initial begin
    reset = 1'b1;
    clear_inputs();
    @(posedge clk);
    #1;
    model_reset();

    // Reset state, then idle.
    step();
    reset = 1'b0;
    q_index1 = 5'd3;
    q_index2 = 5'd0;
    repeat (3) step();

    // Two constant requesters alternate.
    set_req(0, 1'b1, 3, 32'h11);
    set_req(1, 1'b1, 4, 32'h22);
    repeat (5) step();
    clear_inputs();
    step();

    // Reserve x5, commit it three cycles later from requester 2.
    q_index1  = 5'd5;
    rsv_valid = 1'b1;
    rsv_index = 5'd5;
    step();
    rsv_valid = 1'b0;
    repeat (2) step();
    set_req(2, 1'b1, 5, 32'hDEADBEEF);
    step();
    bus.req_valid = '0;
    repeat (3) step();

    // Saturate x7, hold the fourth reservation, then commit under it.
    q_index2  = 5'd7;
    rsv_valid = 1'b1;
    rsv_index = 5'd7;
    repeat (5) step();
    set_req(0, 1'b1, 7, 32'h77);
    step();
    bus.req_valid = '0;
    repeat (3) step();
    rsv_valid = 1'b0;
    repeat (8) begin
      set_req(0, 1'b1, 7, $urandom);
      step();
    end
    bus.req_valid = '0;
    repeat (2) step();

    // Write to x0 is granted but never enabled.
    q_index1 = 5'd0;
    set_req(1, 1'b1, 0, 32'hFFFFFFFF);
    step();
    bus.req_valid = '0;
    repeat (2) step();

    // Reset with reservations pending and a grant in flight.
    q_index1  = 5'd9;
    q_index2  = 5'd10;
    rsv_valid = 1'b1;
    rsv_index = 5'd9;
    step();
    rsv_index = 5'd10;
    step();
    rsv_valid = 1'b0;
    set_req(1, 1'b1, 9, 32'h99);
    step();
    reset = 1'b1;
    set_req(0, 1'b1, 2, 32'hA0);
    set_req(2, 1'b1, 6, 32'hA2);
    step();
    reset = 1'b0;
    repeat (4) step();
    clear_inputs();

    // Randomized traffic over a small register window to force collisions.
    for (int c = 0; c < 400; c++) begin
      reset = ($urandom_range(0, 59) == 0);
      for (int i = 0; i < NR; i++) begin
        set_req(i, 1'($urandom_range(0, 1)), int'($urandom_range(0, 7)), $urandom);
      end
      rsv_valid = 1'($urandom_range(0, 1));
      rsv_index = 5'($urandom_range(0, 7));
      q_index1  = 5'($urandom_range(0, 7));
      q_index2  = 5'($urandom_range(0, 7));
      step();
    end
    reset = 1'b0;
    clear_inputs();
    step();

    @(negedge clk);
    #1;
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
